// File: rtl/phy_map_pkg.sv
// Shared constellation definitions: modes, Gray-to-level decode and
// unit-power level codes computed for any component width up to 32 bits.
package phy_map_pkg;

  typedef enum logic [1:0] {
    MODE_BPSK  = 2'd0,
    MODE_QPSK  = 2'd1,
    MODE_QAM16 = 2'd2,
    MODE_QAM64 = 2'd3
  } mode_e;

  // Per-mode normalisation 1/sqrt(Es) held as Q2.30.
  localparam longint K_BPSK  = 64'd1073741824;
  localparam longint K_QPSK  = 64'd759250125;
  localparam longint K_QAM16 = 64'd339546978;
  localparam longint K_QAM64 = 64'd165681960;

  function automatic logic [1:0] bits_per_axis(mode_e m);
    case (m)
      MODE_QAM16: return 2'd2;
      MODE_QAM64: return 2'd3;
      default:    return 2'd1;
    endcase
  endfunction

  function automatic logic signed [3:0] gray_level(mode_e m, logic [2:0] g);
    logic signed [3:0] lvl;
    lvl = 4'sd0;
    case (m)
      MODE_QAM16:
        case (g[1:0])
          2'b00:   lvl = -4'sd3;
          2'b01:   lvl = -4'sd1;
          2'b11:   lvl = 4'sd1;
          default: lvl = 4'sd3;
        endcase
      MODE_QAM64:
        case (g)
          3'b000:  lvl = -4'sd7;
          3'b001:  lvl = -4'sd5;
          3'b011:  lvl = -4'sd3;
          3'b010:  lvl = -4'sd1;
          3'b110:  lvl = 4'sd1;
          3'b111:  lvl = 4'sd3;
          3'b101:  lvl = 4'sd5;
          default: lvl = 4'sd7;
        endcase
      default: lvl = g[0] ? 4'sd1 : -4'sd1;
    endcase
    return lvl;
  endfunction

  // round(mag * k * 2^(dw-2)) from a Q2.30 scale factor; valid for dw <= 32.
  function automatic longint level_code(int dw, longint k_q30, int mag);
    longint p;
    longint sh;
    p  = k_q30 * longint'(mag);
    sh = longint'(32 - dw);
    if (sh > 0)
      return (p + (longint'(1) <<< (sh - 1))) >>> sh;
    return p;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO; read data is the head, or the last popped word when empty.
module sync_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                       CLK_I,
  input  logic                       RST_I,
  input  logic                       wr_en,
  input  logic [W-1:0]               wr_data,
  input  logic                       rd_en,
  output logic [W-1:0]               rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [W-1:0]  last_q;
  logic          do_wr, do_rd;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_rd   = rd_en & ~empty;
  assign do_wr   = wr_en & (~full | do_rd);
  assign rd_data = empty ? last_q : mem[rd_ptr];

  always_ff @(posedge CLK_I) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      last_q <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
        last_q <= mem[rd_ptr];
      end
      count <= count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end
  end

endmodule

// File: rtl/qam_mapper_multi.sv
// Run-time selectable BPSK/QPSK/16QAM/64QAM mapper with per-frame mode latch
// and credit-based input acceptance decoupled from the downstream ACK_I.
module qam_mapper_multi
  import phy_map_pkg::*;
#(
  parameter int DW    = 16,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  input  logic [5:0]        DAT_I,
  input  logic [1:0]        MODE_I,
  input  logic              CYC_I,
  input  logic              STB_I,
  input  logic              WE_I,
  output logic              ACK_O,
  output logic [2*DW-1:0]   DAT_O,
  output logic              CYC_O,
  output logic              STB_O,
  output logic              WE_O,
  input  logic              ACK_I,
  output logic [CNT_W-1:0]  SYM_CNT_O
);
  localparam int CW = $clog2(DEPTH) + 1;

  localparam logic [DW-1:0] LV_BPSK  = DW'(level_code(DW, K_BPSK, 1));
  localparam logic [DW-1:0] LV_QPSK  = DW'(level_code(DW, K_QPSK, 1));
  localparam logic [DW-1:0] LV16_1   = DW'(level_code(DW, K_QAM16, 1));
  localparam logic [DW-1:0] LV16_3   = DW'(level_code(DW, K_QAM16, 3));
  localparam logic [DW-1:0] LV64_1   = DW'(level_code(DW, K_QAM64, 1));
  localparam logic [DW-1:0] LV64_3   = DW'(level_code(DW, K_QAM64, 3));
  localparam logic [DW-1:0] LV64_5   = DW'(level_code(DW, K_QAM64, 5));
  localparam logic [DW-1:0] LV64_7   = DW'(level_code(DW, K_QAM64, 7));

  function automatic logic [DW-1:0] scale(mode_e m, logic signed [3:0] lvl);
    logic [3:0]    mag;
    logic [DW-1:0] v;
    mag = lvl[3] ? 4'(-lvl) : 4'(lvl);
    case (m)
      MODE_BPSK:  v = LV_BPSK;
      MODE_QPSK:  v = LV_QPSK;
      MODE_QAM16: v = (mag == 4'd3) ? LV16_3 : LV16_1;
      default:
        case (mag)
          4'd1:    v = LV64_1;
          4'd3:    v = LV64_3;
          4'd5:    v = LV64_5;
          default: v = LV64_7;
        endcase
    endcase
    return lvl[3] ? -v : v;
  endfunction

  logic           icyc, frame_start, ena, accept, pop;
  mode_e          mode_q, acc_mode;
  logic [CW-1:0]  credit;
  logic           s1_v;
  logic [5:0]     s1_dat;
  mode_e          s1_mode;
  logic           cyc_q;
  logic [CNT_W-1:0] sym_cnt;

  logic [1:0]     bpa;
  logic [5:0]     mask;
  logic [2:0]     gi, gq;
  logic [DW-1:0]  map_i, map_q;

  logic           fifo_empty, fifo_full;
  logic [CW-1:0]  fifo_cnt;
  logic           fifo_unused;

  assign ena         = CYC_I & STB_I & WE_I;
  assign frame_start = CYC_I & ~icyc;
  // The first group of a frame may arrive on the frame-start cycle itself.
  assign acc_mode    = frame_start ? mode_e'(MODE_I) : mode_q;
  assign accept      = ena & RST_I & (credit < CW'(DEPTH));
  assign pop         = STB_O & ACK_I;

  assign ACK_O       = accept;
  assign STB_O       = ~fifo_empty;
  assign WE_O        = STB_O;
  assign CYC_O       = cyc_q;
  assign SYM_CNT_O   = sym_cnt;

  assign bpa   = bits_per_axis(s1_mode);
  assign mask  = (6'd1 << bpa) - 6'd1;
  assign gi    = 3'(s1_dat & mask);
  assign gq    = 3'((s1_dat >> bpa) & mask);
  assign map_i = scale(s1_mode, gray_level(s1_mode, gi));
  assign map_q = (s1_mode == MODE_BPSK) ? '0 : scale(s1_mode, gray_level(s1_mode, gq));

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      icyc    <= 1'b0;
      mode_q  <= MODE_BPSK;
      credit  <= '0;
      s1_v    <= 1'b0;
      s1_dat  <= '0;
      s1_mode <= MODE_BPSK;
      cyc_q   <= 1'b0;
      sym_cnt <= '0;
    end else begin
      icyc   <= CYC_I;
      if (frame_start) mode_q <= mode_e'(MODE_I);
      credit <= credit + CW'(accept) - CW'(pop);
      s1_v   <= accept;
      if (accept) begin
        s1_dat  <= DAT_I;
        s1_mode <= acc_mode;
      end
      cyc_q <= icyc | (credit != '0);
      if (frame_start)
        sym_cnt <= pop ? CNT_W'(1) : '0;
      else if (pop)
        sym_cnt <= sym_cnt + 1'b1;
    end
  end

  sync_fifo #(.W(2*DW), .DEPTH(DEPTH)) u_fifo (
    .CLK_I   (CLK_I),
    .RST_I   (RST_I),
    .wr_en   (s1_v),
    .wr_data ({map_q, map_i}),
    .rd_en   (pop),
    .rd_data (DAT_O),
    .count   (fifo_cnt),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  // Occupancy is tracked by credit; FIFO status flags are informational here.
  assign fifo_unused = ^{fifo_full, fifo_cnt};

endmodule

// File: tb/tb_qam_mapper_multi.sv
// Randomized bench for qam_mapper_multi against a real-arithmetic constellation model.
module tb_qam_mapper_multi;
  localparam int DW = 16, DEPTH = 4, CNT_W = 16;

  logic              CLK_I = 1'b0, RST_I = 1'b0;
  logic [5:0]        DAT_I = '0;
  logic [1:0]        MODE_I = '0;
  logic              CYC_I = 1'b0, STB_I = 1'b0, WE_I = 1'b0, ACK_I = 1'b0;
  logic              ACK_O, CYC_O, STB_O, WE_O;
  logic [2*DW-1:0]   DAT_O;
  logic [CNT_W-1:0]  SYM_CNT_O;

  qam_mapper_multi #(.DW(DW), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .DAT_I(DAT_I), .MODE_I(MODE_I),
    .CYC_I(CYC_I), .STB_I(STB_I), .WE_I(WE_I), .ACK_O(ACK_O),
    .DAT_O(DAT_O), .CYC_O(CYC_O), .STB_O(STB_O), .WE_O(WE_O),
    .ACK_I(ACK_I), .SYM_CNT_O(SYM_CNT_O)
  );

  always #5 CLK_I = ~CLK_I;

  int n_tests = 0, n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: Gray -> binary index -> odd integer level -> unit average power.
  function automatic logic [15:0] ref_axis(int norm, int k, int g);
    int  b, lvl, v;
    real r;
    b   = g ^ (g >> 1) ^ (g >> 2);
    lvl = 2 * b - ((1 << k) - 1);
    r   = real'(lvl) * 16384.0 / $sqrt(real'(norm));
    v   = int'(r);
    return 16'(v);
  endfunction

  function automatic logic [31:0] ref_sym(logic [1:0] m, logic [5:0] d);
    int di, k, norm, mask;
    di = int'(d);
    case (m)
      2'd0:    return {16'h0000, ref_axis(1, 1, di & 1)};
      2'd1:    begin k = 1; norm = 2;  end
      2'd2:    begin k = 2; norm = 10; end
      default: begin k = 3; norm = 42; end
    endcase
    mask = (1 << k) - 1;
    return {ref_axis(norm, k, (di >> k) & mask), ref_axis(norm, k, di & mask)};
  endfunction

  typedef struct { logic [31:0] d; int ec; } ent_t;
  ent_t       q[$];
  int         ec = 0;
  logic [1:0] mode_m = 2'd0;
  logic       prev_cyc_m = 1'b0, cyc_o_m = 1'b0;
  int         cnt_m = 0;
  bit         in_rst = 1'b1;
  int         ack_mode = 1;

  always @(posedge CLK_I) ec++;

  always @(posedge CLK_I) begin
    #1;
    case (ack_mode)
      0:       ACK_I = 1'b0;
      1:       ACK_I = 1'b1;
      default: ACK_I = ($urandom_range(3) != 0);
    endcase
  end

  always @(negedge CLK_I) begin
    bit         ena, exp_ack, exp_stb, pop, fs;
    int         sz;
    logic [1:0] cur;
    if (!in_rst) begin
      sz      = q.size();
      ena     = CYC_I && STB_I && WE_I;
      exp_ack = ena && (sz < DEPTH);
      exp_stb = 1'b0;
      if (sz > 0) exp_stb = (ec >= q[0].ec + 2);
      check("ack_o", 64'(ACK_O), 64'(exp_ack));
      check("stb_o", 64'(STB_O), 64'(exp_stb));
      check("we_o", 64'(WE_O), 64'(exp_stb));
      if (exp_stb) check("dat_o", 64'(DAT_O), 64'(q[0].d));
      check("cyc_o", 64'(CYC_O), 64'(cyc_o_m));
      check("sym_cnt", 64'(SYM_CNT_O), 64'(cnt_m));
      fs      = CYC_I && !prev_cyc_m;
      cur     = fs ? MODE_I : mode_m;
      pop     = exp_stb && ACK_I;
      cyc_o_m = prev_cyc_m || (sz != 0);
      if (pop) void'(q.pop_front());
      if (exp_ack) q.push_back('{ref_sym(cur, DAT_I), ec});
      if (fs) cnt_m = pop ? 1 : 0;
      else if (pop) cnt_m = (cnt_m + 1) & 16'hFFFF;
      mode_m     = cur;
      prev_cyc_m = CYC_I;
    end
  end

  task automatic tick();
    @(posedge CLK_I);
    #1;
  endtask

  task automatic push(input logic [5:0] d);
    int n;
    DAT_I = d; STB_I = 1'b1; WE_I = 1'b1;
    n = 0;
    @(negedge CLK_I);
    while (!ACK_O && n < 200) begin
      n++;
      @(negedge CLK_I);
    end
    if (!ACK_O) check("push_timeout", 64'(ACK_O), 64'd1);
    tick();
    STB_I = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 500) begin
      tick();
      n++;
    end
    check("drain_timeout", 64'(q.size()), 64'd0);
  endtask

  task automatic model_clear();
    q.delete();
    mode_m = 2'd0; prev_cyc_m = 1'b0; cyc_o_m = 1'b0; cnt_m = 0;
  endtask

  initial begin
    int nacks, nsym;
    repeat (2) tick();
    // Reset state, with an active write request present
    CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b1;
    #1;
    check("rst_ack", 64'(ACK_O), 64'd0);
    check("rst_stb", 64'(STB_O), 64'd0);
    check("rst_cyc", 64'(CYC_O), 64'd0);
    check("rst_dat", 64'(DAT_O), 64'd0);
    check("rst_cnt", 64'(SYM_CNT_O), 64'd0);
    CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
    tick();
    RST_I = 1'b1; in_rst = 1'b0;
    tick();

    // 16QAM directed: I=11 -> +1, Q=10 -> +3
    CYC_I = 1'b1; MODE_I = 2'd2;
    push(6'b001011);
    tick();
    check("qam16_dat", 64'(DAT_O), 64'h3CB7_143D);
    check("qam16_stb", 64'(STB_O), 64'd1);
    drain();
    CYC_I = 1'b0; tick();

    // 64QAM full sweep with random backpressure
    CYC_I = 1'b1; MODE_I = 2'd3; ack_mode = 2;
    for (int i = 0; i < 64; i++) push(6'(i));
    drain();
    ack_mode = 1; CYC_I = 1'b0; tick();

    // Backpressure: exactly DEPTH accepts with ACK_I low
    ack_mode = 0; tick(); tick();
    CYC_I = 1'b1; MODE_I = 2'd1; STB_I = 1'b1; WE_I = 1'b1;
    nacks = 0;
    repeat (10) begin
      @(negedge CLK_I);
      if (ACK_O) nacks++;
      tick();
      DAT_I = 6'($urandom);
    end
    check("bp_acks", 64'(nacks), 64'(DEPTH));
    STB_I = 1'b0; ack_mode = 1;
    tick();
    nsym = 0;
    repeat (DEPTH) begin
      @(negedge CLK_I);
      if (STB_O) nsym++;
      tick();
    end
    check("bp_burst", 64'(nsym), 64'(DEPTH));
    drain();
    CYC_I = 1'b0; tick();

    // QPSK frame queued behind a BPSK frame start
    ack_mode = 0; tick();
    CYC_I = 1'b1; MODE_I = 2'd1;
    repeat (3) push(6'($urandom));
    CYC_I = 1'b0; tick();
    CYC_I = 1'b1; MODE_I = 2'd0;
    push(6'($urandom));
    tick();
    check("frame2_cnt", 64'(SYM_CNT_O), 64'd0);
    ack_mode = 1;
    drain();
    CYC_I = 1'b0;
    repeat (3) tick();

    // Mode toggling mid-frame must not affect mapping
    CYC_I = 1'b1; MODE_I = 2'd2; ack_mode = 2;
    push(6'($urandom));
    for (int i = 0; i < 20; i++) begin
      MODE_I = 2'($urandom);
      push(6'($urandom));
    end
    drain();
    CYC_I = 1'b0; tick();

    // Random frames, sometimes back-to-back with symbols still queued
    for (int f = 0; f < 8; f++) begin
      CYC_I = 1'b1; MODE_I = 2'($urandom);
      for (int i = 0, n = $urandom_range(12, 1); i < n; i++) begin
        push(6'($urandom));
        if ($urandom_range(2) == 0) tick();
      end
      CYC_I = 1'b0; tick();
      if ($urandom_range(1) == 0) drain();
    end
    drain();
    ack_mode = 1; repeat (3) tick();

    // Reset with symbols queued
    ack_mode = 0; tick();
    CYC_I = 1'b1; MODE_I = 2'd3;
    repeat (3) push(6'($urandom));
    tick();
    in_rst = 1'b1; RST_I = 1'b0; STB_I = 1'b1; WE_I = 1'b1;
    #1;
    check("mrst_ack", 64'(ACK_O), 64'd0);
    check("mrst_stb", 64'(STB_O), 64'd0);
    check("mrst_we", 64'(WE_O), 64'd0);
    check("mrst_cyc", 64'(CYC_O), 64'd0);
    check("mrst_dat", 64'(DAT_O), 64'd0);
    check("mrst_cnt", 64'(SYM_CNT_O), 64'd0);
    model_clear();
    CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0; MODE_I = 2'd0;
    tick(); tick();
    ack_mode = 1; RST_I = 1'b1; in_rst = 1'b0;
    tick();
    CYC_I = 1'b1;
    push(6'($urandom));
    tick();
    check("post_rst_bpsk", 64'(DAT_O), DAT_I[0] ? 64'h0000_4000 : 64'h0000_C000);
    drain();
    CYC_I = 1'b0;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
